// File: rtl/ace_loader_pkg.sv
// ace_loader_pkg
//   Shared definitions for the .ACE snapshot loader:
//   - ld_state_t        : loader state machine encoding (also exported on
//                         the loader's dbg_state port)
//   - RLE_ESC           : escape byte of the RLE stream
//   - LOAD_BASE_DEFAULT : default first destination address in Ace RAM
//   - is_parsing()      : true in the states where a falling download
//                         means the file was truncated
package ace_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LIT  = 3'd1,
    ST_CNT  = 3'd2,
    ST_VAL  = 3'd3,
    ST_RUN  = 3'd4,
    ST_HOLD = 3'd5
  } ld_state_t;

  localparam logic [7:0]  RLE_ESC           = 8'hED;
  localparam logic [15:0] LOAD_BASE_DEFAULT = 16'h2000;

  // States in which the stream is still being decoded. HOLD is excluded:
  // once the end marker has been seen, the download is allowed to end.
  function automatic logic is_parsing(input ld_state_t s);
    return (s == ST_LIT) || (s == ST_CNT) || (s == ST_VAL) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/ace_rle_loader.sv
// ace_rle_loader
//   Decompresses an RLE-encoded .ACE snapshot arriving on the hps_io ioctl
//   download interface into byte writes on the Jupiter Ace RAM write port,
//   starting at LOAD_BASE. The Ace core is held in reset for the whole load.
//
//   Stream format:
//     byte != ED   literal, written once
//     ED n v       (n != 0) write v, n times
//     ED 00        end of data
//     ED 01 ED     encodes a literal ED
//
//   Parameters
//     LOAD_BASE    first destination address
//     HOLD_CYCLES  cycles ioctl_wait stays high after the end marker, so
//                  trailing bytes of the file are swallowed
//
//   Ports
//     clk_sys         in   system clock, rising edge
//     reset           in   synchronous, active-high
//     ioctl_download  in   download in progress
//     ioctl_index     in   file index, nonzero selects an ACE load
//     ioctl_wr        in   one-cycle strobe, ioctl_dout valid with it
//     ioctl_dout      in   stream byte
//     ioctl_wait      out  stall request to hps_io
//     mem_addr        out  RAM write address
//     mem_data        out  RAM write data
//     mem_wr          out  write request, held until accepted
//     mem_ready       in   write accepted on any cycle with mem_wr & mem_ready
//     core_reset      out  holds the Ace core in reset (ORed into its reset)
//     done            out  sticky: last load ended on a valid end marker
//     error           out  sticky: last load was truncated or overflowed
//     dbg_state       out  current state (ld_state_t encoding)
//
//   Handshake: a RAM write is offered by raising mem_wr with stable
//   mem_addr/mem_data; it completes on the first rising edge where
//   mem_wr & mem_ready are both high, and mem_wr/mem_addr/mem_data do not
//   change before that edge. ioctl_wait is high while a write or run is
//   outstanding; hps_io does not strobe ioctl_wr while it is high, and a
//   strobe that arrives while a write is pending is dropped.
//
//   At the top level core_reset is ORed into the Ace reset and selects the
//   loader's mem_* signals onto the RAM write port.
module ace_rle_loader
  import ace_loader_pkg::*;
#(
  parameter logic [15:0] LOAD_BASE   = LOAD_BASE_DEFAULT,
  parameter int          HOLD_CYCLES = 3_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        mem_ready,
  output logic        core_reset,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

  ld_state_t         state;
  logic [7:0]        run_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              dl_q;

  logic start;
  logic abort;
  logic accept;
  logic at_top;

  // A load starts on a rising download edge with a nonzero index. The edge
  // is honoured in every state so a new download always restarts cleanly.
  assign start  = ioctl_download & ~dl_q & (ioctl_index != 8'd0);
  assign abort  = ~ioctl_download & is_parsing(state);
  assign accept = mem_wr & mem_ready;
  assign at_top = (mem_addr == 16'hFFFF);

  assign dbg_state = state;

  // Download edge history is sampled even during reset, so a reset issued
  // while a download is still high does not look like a fresh start.
  always_ff @(posedge clk_sys) begin
    dl_q <= ioctl_download;
  end

  // Within a load, error can only be set by an address overflow (a
  // truncation ends the load), so error doubles as the "stop writing" flag
  // that lets the rest of the stream be parsed and discarded.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      ioctl_wait <= 1'b0;
      mem_addr   <= LOAD_BASE;
      mem_data   <= 8'd0;
      mem_wr     <= 1'b0;
      core_reset <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      run_cnt    <= 8'd0;
      hold_cnt   <= '0;
    end else if (start) begin
      // Takes priority over any write acceptance in the same cycle.
      state      <= ST_LIT;
      mem_addr   <= LOAD_BASE;
      mem_wr     <= 1'b0;
      ioctl_wait <= 1'b0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      run_cnt    <= 8'd0;
      hold_cnt   <= '0;
    end else if (abort) begin
      // File ended before the end marker: drop any pending write.
      state      <= ST_IDLE;
      mem_wr     <= 1'b0;
      ioctl_wait <= 1'b0;
      core_reset <= 1'b0;
      error      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          // Waiting for a download edge, handled above.
        end

        ST_LIT: begin
          if (mem_wr) begin
            if (accept) begin
              mem_wr     <= 1'b0;
              ioctl_wait <= 1'b0;
              if (at_top) begin
                error <= 1'b1;
              end else begin
                mem_addr <= mem_addr + 16'd1;
              end
            end
          end else if (ioctl_wr) begin
            if (ioctl_dout == RLE_ESC) begin
              state <= ST_CNT;
            end else if (!error) begin
              mem_data   <= ioctl_dout;
              mem_wr     <= 1'b1;
              ioctl_wait <= 1'b1;
            end
          end
        end

        ST_CNT: begin
          if (ioctl_wr) begin
            if (ioctl_dout == 8'd0) begin
              state      <= ST_HOLD;
              ioctl_wait <= 1'b1;
              hold_cnt   <= HOLD_INIT;
            end else begin
              run_cnt <= ioctl_dout;
              state   <= ST_VAL;
            end
          end
        end

        ST_VAL: begin
          if (ioctl_wr) begin
            if (error) begin
              // After an overflow the run is parsed but not written.
              state <= ST_LIT;
            end else begin
              mem_data   <= ioctl_dout;
              mem_wr     <= 1'b1;
              ioctl_wait <= 1'b1;
              state      <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          // run_cnt is at least 1 on entry, so the write stays requested
          // until the acceptance that brings it to zero.
          if (accept) begin
            run_cnt <= run_cnt - 8'd1;
            if (at_top) begin
              error      <= 1'b1;
              mem_wr     <= 1'b0;
              ioctl_wait <= 1'b0;
              state      <= ST_LIT;
            end else begin
              mem_addr <= mem_addr + 16'd1;
              if (run_cnt == 8'd1) begin
                mem_wr     <= 1'b0;
                ioctl_wait <= 1'b0;
                state      <= ST_LIT;
              end
            end
          end
        end

        ST_HOLD: begin
          // Incoming bytes are ignored; the core stays in reset until the
          // hold has expired and hps_io has ended the download.
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else begin
            ioctl_wait <= 1'b0;
            done       <= 1'b1;
            if (!ioctl_download) begin
              core_reset <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ace_rle_loader.sv
// tb_ace_rle_loader
//   Bench for ace_rle_loader. Two instances share the stimulus: u_dut loads
//   at 0x2000 and u_hi loads at 0xFFFE for the overflow case; sel_hi picks
//   which one the driver and monitor follow.
module tb_ace_rle_loader;
  import ace_loader_pkg::*;

  localparam int HOLD = 12;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        mem_ready;

  logic        ioctl_wait, mem_wr, core_reset, done, error;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [2:0]  dbg_state;

  logic        hi_wait, hi_wr, hi_core_reset, hi_done, hi_error;
  logic [15:0] hi_addr;
  logic [7:0]  hi_data;
  logic [2:0]  hi_state;

  ace_rle_loader #(.LOAD_BASE(16'h2000), .HOLD_CYCLES(HOLD)) u_dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .core_reset(core_reset), .done(done),
    .error(error), .dbg_state(dbg_state)
  );

  ace_rle_loader #(.LOAD_BASE(16'hFFFE), .HOLD_CYCLES(HOLD)) u_hi (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(hi_wait),
    .mem_addr(hi_addr), .mem_data(hi_data), .mem_wr(hi_wr),
    .mem_ready(mem_ready), .core_reset(hi_core_reset), .done(hi_done),
    .error(hi_error), .dbg_state(hi_state)
  );

  bit sel_hi = 1'b0;
  logic        s_wait, s_wr, s_core_reset, s_done, s_error;
  logic [15:0] s_addr;
  logic [7:0]  s_data;
  logic [2:0]  s_state;
  assign s_wait       = sel_hi ? hi_wait       : ioctl_wait;
  assign s_wr         = sel_hi ? hi_wr         : mem_wr;
  assign s_core_reset = sel_hi ? hi_core_reset : core_reset;
  assign s_done       = sel_hi ? hi_done       : done;
  assign s_error      = sel_hi ? hi_error      : error;
  assign s_addr       = sel_hi ? hi_addr       : mem_addr;
  assign s_data       = sel_hi ? hi_data       : mem_data;
  assign s_state      = sel_hi ? hi_state      : dbg_state;

  // ---------------- mem_ready driver ----------------
  // 0: always ready, 1: toggling, 2: random, 4: manual (manual_ready)
  int   ready_mode = 0;
  logic auto_ready = 1'b1;
  logic manual_ready = 1'b0;
  assign mem_ready = (ready_mode == 4) ? manual_ready : auto_ready;

  always @(posedge clk_sys) begin
    #1;
    case (ready_mode)
      0:       auto_ready = 1'b1;
      1:       auto_ready = ~auto_ready;
      2:       auto_ready = ($urandom_range(0, 2) != 0);
      default: auto_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  logic [23:0] obs_q[$];
  int          stall_viol = 0;
  bit          mon_en = 1'b0;
  logic        prev_pend = 1'b0;
  logic [23:0] prev_ad = '0;

  always @(negedge clk_sys) begin
    if (mon_en && s_wr && mem_ready) obs_q.push_back({s_addr, s_data});
    if (mon_en && prev_pend && s_wr && ({s_addr, s_data} != prev_ad)) stall_viol++;
    prev_pend = s_wr & ~mem_ready;
    prev_ad   = {s_addr, s_data};
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  int          obs_base;
  int          stall_base;
  bit          mdl_end;
  bit          mdl_ovf;
  int          mdl_nwr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference decode: expands the stream into the list of {addr,data}
  // writes it should produce, stopping at the end marker, at a cut-off
  // stream, or after the write that lands on 0xFFFF.
  task automatic model_stream(input logic [7:0] s[$], input int base);
    int a;
    int i;
    int n;
    logic [7:0] v;
    a = base; i = 0; mdl_end = 1'b0; mdl_ovf = 1'b0; mdl_nwr = 0;
    exp_q.delete();
    while (i < s.size() && !mdl_end) begin
      if (s[i] != 8'hED) begin
        n = 1; v = s[i]; i = i + 1;
      end else begin
        if (i + 1 >= s.size()) break;
        n = int'(s[i+1]);
        if (n == 0) begin
          mdl_end = 1'b1;
          break;
        end
        if (i + 2 >= s.size()) break;
        v = s[i+2]; i = i + 3;
      end
      for (int k = 0; k < n; k++) begin
        if (!mdl_ovf) begin
          exp_q.push_back({a[15:0], v});
          mdl_nwr++;
          if (a == 32'hFFFF) mdl_ovf = 1'b1;
          else a = a + 1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk_sys); #1;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_dout = 8'd0;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
  endtask

  task automatic begin_load(input logic [7:0] idx);
    obs_base = obs_q.size();
    stall_base = stall_viol;
    mon_en = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    ioctl_dout = b;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  // One byte with at least 4 idle cycles after it, then honour ioctl_wait.
  task automatic send_byte(input logic [7:0] b);
    int g;
    check("strobe_while_pending", s_wr, 1'b0);
    strobe(b);
    repeat (4) @(posedge clk_sys);
    #1;
    g = 0;
    while (s_wait && g < 3000) begin
      @(posedge clk_sys); #1;
      g++;
    end
    check("wait_timeout", (g < 3000), 1'b1);
  endtask

  task automatic finish_load(input bit end_seen);
    int g;
    int n_obs;
    if (end_seen) begin
      g = 0;
      while (!s_done && g < HOLD + 200) begin
        @(posedge clk_sys); #1;
        g++;
      end
      check("done_timeout", (g < HOLD + 200), 1'b1);
      check("core_reset_held_after_done", s_core_reset, 1'b1);
    end
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    check("end_state_idle", s_state, ST_IDLE);
    check("end_core_reset", s_core_reset, 1'b0);
    check("end_mem_wr", s_wr, 1'b0);
    check("end_ioctl_wait", s_wait, 1'b0);
    n_obs = obs_q.size() - obs_base;
    check("write_count", n_obs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_obs; i++)
      check("write_addr_data", obs_q[obs_base + i], exp_q[i]);
    check("stall_stable", stall_viol - stall_base, 0);
    mon_en = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] s[$]);
    do_reset();
    model_stream(s, sel_hi ? 32'hFFFE : 32'h2000);
    begin_load(8'($urandom_range(1, 255)));
    foreach (s[i]) send_byte(s[i]);
    finish_load(mdl_end);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] bytes;     // stream, first byte in [63:56]
    int          len;
    int          rmode;
    bit          hi;
    int          exp_writes;
    bit          exp_done;
    bit          exp_error;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  sq[$];

  initial begin
    int k;
    int items;
    int n;
    logic [7:0] b;
    bit trunc;

    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_dout = 8'd0;

    tbl[0] = '{64'h010203ED00000000, 5, 0, 1'b0, 3, 1'b1, 1'b0, 16'h2003};
    tbl[1] = '{64'hED05AAED01EDED00, 8, 0, 1'b0, 6, 1'b1, 1'b0, 16'h2006};
    tbl[2] = '{64'hED05AAED01EDED00, 8, 1, 1'b0, 6, 1'b1, 1'b0, 16'h2006};
    tbl[3] = '{64'h11ED030000000000, 3, 0, 1'b0, 1, 1'b0, 1'b1, 16'h2001};
    tbl[4] = '{64'hED0455ED00000000, 5, 0, 1'b1, 2, 1'b1, 1'b1, 16'hFFFF};
    tbl[5] = '{64'hED03ED42ED000000, 6, 2, 1'b0, 4, 1'b1, 1'b0, 16'h2004};

    // Reset values
    do_reset();
    check("rst_ioctl_wait", ioctl_wait, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_core_reset", core_reset, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h2000);
    check("rst_mem_data", mem_data, 8'h00);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_hi_addr", hi_addr, 16'hFFFE);

    // Table-driven loads
    for (int i = 0; i < 6; i++) begin
      sel_hi = tbl[i].hi;
      ready_mode = tbl[i].rmode;
      sq.delete();
      for (k = 0; k < tbl[i].len; k++) sq.push_back(tbl[i].bytes[63 - 8*k -: 8]);
      run_load(sq);
      check($sformatf("v%0d_writes", i), obs_q.size() - obs_base, tbl[i].exp_writes);
      check($sformatf("v%0d_done", i), s_done, tbl[i].exp_done);
      check($sformatf("v%0d_error", i), s_error, tbl[i].exp_error);
      check($sformatf("v%0d_addr", i), s_addr, tbl[i].exp_addr);
    end
    sel_hi = 1'b0;

    // Literal latency, stall stability, then run timing in the same load
    do_reset();
    ready_mode = 4; manual_ready = 1'b0;
    exp_q.delete();
    exp_q.push_back({16'h2000, 8'h5A});
    for (k = 0; k < 4; k++) exp_q.push_back({16'(16'h2001 + k), 8'h77});
    obs_base = obs_q.size(); stall_base = stall_viol; mon_en = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_index = 8'd3; ioctl_download = 1'b1;
    check("core_reset_before_edge", core_reset, 1'b0);
    @(posedge clk_sys); #1;
    check("core_reset_rise", core_reset, 1'b1);
    check("start_state_lit", dbg_state, ST_LIT);
    strobe(8'h5A);
    check("lit_mem_wr_n1", mem_wr, 1'b1);
    check("lit_wait_n1", ioctl_wait, 1'b1);
    check("lit_data", mem_data, 8'h5A);
    repeat (3) @(posedge clk_sys);
    #1;
    check("lit_stall_wr", mem_wr, 1'b1);
    check("lit_stall_addr", mem_addr, 16'h2000);
    manual_ready = 1'b1;
    @(posedge clk_sys); #1;
    manual_ready = 1'b0;
    check("lit_wr_drop", mem_wr, 1'b0);
    check("lit_wait_drop", ioctl_wait, 1'b0);
    check("lit_addr_inc", mem_addr, 16'h2001);
    ready_mode = 0;
    send_byte(8'hED);
    send_byte(8'h04);
    strobe(8'h77);
    n = 0;
    while (ioctl_wait && n < 20) begin
      n++;
      @(posedge clk_sys); #1;
    end
    check("run_wait_cycles", n, 4);
    check("run_end_addr", mem_addr, 16'h2005);
    check("run_end_state", dbg_state, ST_LIT);
    send_byte(8'hED);
    send_byte(8'h00);
    finish_load(1'b1);
    check("seq_done", done, 1'b1);
    check("seq_error", error, 1'b0);

    // Reset in the middle of a 100-write run
    do_reset();
    ready_mode = 4; manual_ready = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    send_byte(8'hED);
    send_byte(8'd100);
    strobe(8'h33);
    check("mid_run_state", dbg_state, ST_RUN);
    check("mid_run_wr", mem_wr, 1'b1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    check("rr_wait", ioctl_wait, 1'b0);
    check("rr_wr", mem_wr, 1'b0);
    check("rr_core_reset", core_reset, 1'b0);
    check("rr_done", done, 1'b0);
    check("rr_error", error, 1'b0);
    check("rr_addr", mem_addr, 16'h2000);
    check("rr_data", mem_data, 8'h00);
    check("rr_state", dbg_state, ST_IDLE);
    ioctl_download = 1'b0;

    // Index 0 download is ignored
    do_reset();
    ready_mode = 0;
    @(posedge clk_sys); #1;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    strobe(8'h12);
    check("idx0_mem_wr", mem_wr, 1'b0);
    check("idx0_core_reset", core_reset, 1'b0);
    check("idx0_state", dbg_state, ST_IDLE);
    ioctl_download = 1'b0;

    // Randomized streams against the reference decode
    for (int t = 0; t < 12; t++) begin
      ready_mode = $urandom_range(0, 2);
      sq.delete();
      items = $urandom_range(3, 8);
      for (k = 0; k < items; k++) begin
        if ($urandom_range(0, 1) == 0) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hED) begin
            sq.push_back(8'hED); sq.push_back(8'h01); sq.push_back(8'hED);
          end else begin
            sq.push_back(b);
          end
        end else begin
          sq.push_back(8'hED);
          sq.push_back(8'($urandom_range(1, 6)));
          sq.push_back(8'($urandom_range(0, 255)));
        end
      end
      trunc = ($urandom_range(0, 3) == 0);
      if (!trunc) begin
        sq.push_back(8'hED); sq.push_back(8'h00);
      end
      run_load(sq);
      check($sformatf("rnd%0d_done", t), done, mdl_end);
      check($sformatf("rnd%0d_error", t), error, !mdl_end || mdl_ovf);
      check($sformatf("rnd%0d_addr", t), mem_addr, 16'(16'h2000 + mdl_nwr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
